// File: rtl/instruction_fetch_sequencer.sv
// Instruction fetch sequencer: walks the instruction store, issues instructions downstream, and executes HALT/LOOP locally.
// Optional performance counters are compiled in with IFU_PERF_CNT_EN.
//
// state   | meaning
// IDLE    | waiting for start
// FETCH   | read store at pc and decode in the same cycle
// ISSUE   | instruction held on ins_valid until accepted
// DONE    | one-cycle program-end pulse
module instruction_fetch_sequencer #(
    parameter int INS_LEN = 54,
    parameter int ADDR_W  = 10,
    parameter int CNT_W   = 10
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [ADDR_W-1:0]  start_pc,
    input  logic               abort,
    output logic               icache_rd_ctrl_en,
    output logic [ADDR_W-1:0]  icache_rd_ctrl_addr,
    input  logic [INS_LEN-1:0] icache_rd_ctrl_data,
    output logic               ins_valid,
    output logic [INS_LEN-1:0] ins_data,
    input  logic               ins_ready,
    output logic               busy,
    output logic               done,
    output logic               error,
`ifdef IFU_PERF_CNT_EN
    output logic [31:0]        perf_issue_cnt,
    output logic [31:0]        perf_stall_cnt,
`endif
    output logic [ADDR_W-1:0]  pc
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_FETCH = 2'd1;
    localparam logic [1:0] S_ISSUE = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    localparam logic [3:0] OP_HALT = 4'hF;
    localparam logic [3:0] OP_LOOP = 4'hE;

    localparam logic [ADDR_W-1:0] PC_MAX  = '1;
    localparam logic [ADDR_W-1:0] PC_ONE  = ADDR_W'(1);
    localparam logic [CNT_W-1:0]  CNT_ONE = CNT_W'(1);

    logic [1:0]         state_q, state_d;
    logic [ADDR_W-1:0]  pc_q, pc_d;
    logic               loop_active_q, loop_active_d;
    logic [CNT_W-1:0]   loop_cnt_q, loop_cnt_d;
    logic               wrap_pending_q, wrap_pending_d;
    logic               ins_valid_q, ins_valid_d;
    logic [INS_LEN-1:0] ins_data_q, ins_data_d;
    logic               error_q, error_d;

    logic [3:0]         opcode;
    logic [CNT_W-1:0]   loop_count;
    logic [ADDR_W-1:0]  loop_target;
    logic               is_halt;
    logic               is_loop;
    logic               start_go;
    logic               fetch_go;
    logic               wrap_retire;
    logic [ADDR_W-1:0]  pc_inc;

    assign opcode      = icache_rd_ctrl_data[INS_LEN-1 -: 4];
    assign loop_count  = icache_rd_ctrl_data[ADDR_W+CNT_W-1:ADDR_W];
    assign loop_target = icache_rd_ctrl_data[ADDR_W-1:0];
    assign is_halt     = (opcode == OP_HALT);
    assign is_loop     = (opcode == OP_LOOP);
    assign pc_inc      = pc_q + PC_ONE;

    assign start_go = !abort && (state_q == S_IDLE) && start;

    // The last address has been issued: its acceptance ends the program instead of fetching again.
    assign wrap_retire = !abort && (state_q == S_ISSUE) && ins_ready && wrap_pending_q;

    assign fetch_go = !abort &&
                      ((state_q == S_FETCH) ||
                       ((state_q == S_ISSUE) && ins_ready && !wrap_pending_q));

    always_comb begin
        state_d        = state_q;
        pc_d           = pc_q;
        loop_active_d  = loop_active_q;
        loop_cnt_d     = loop_cnt_q;
        wrap_pending_d = wrap_pending_q;
        ins_valid_d    = ins_valid_q;
        ins_data_d     = ins_data_q;
        error_d        = error_q;

        case (state_q)
            S_IDLE: begin
                if (start_go) begin
                    pc_d           = start_pc;
                    error_d        = 1'b0;
                    loop_active_d  = 1'b0;
                    loop_cnt_d     = '0;
                    wrap_pending_d = 1'b0;
                    state_d        = S_FETCH;
                end
            end
            S_ISSUE: begin
                if (wrap_retire) begin
                    error_d        = 1'b1;
                    ins_valid_d    = 1'b0;
                    wrap_pending_d = 1'b0;
                    state_d        = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = state_q;
            end
        endcase

        if (fetch_go) begin
            if (is_halt) begin
                ins_valid_d = 1'b0;
                state_d     = S_DONE;
            end else if (is_loop) begin
                ins_valid_d = 1'b0;
                state_d     = S_FETCH;
                if (!loop_active_q) begin
                    if (loop_count == '0) begin
                        pc_d = pc_inc;
                    end else begin
                        loop_cnt_d    = loop_count;
                        loop_active_d = 1'b1;
                        pc_d          = loop_target;
                    end
                end else if (loop_cnt_q > CNT_ONE) begin
                    loop_cnt_d = loop_cnt_q - CNT_ONE;
                    pc_d       = loop_target;
                end else begin
                    loop_active_d = 1'b0;
                    loop_cnt_d    = '0;
                    pc_d          = pc_inc;
                end
            end else begin
                ins_data_d  = icache_rd_ctrl_data;
                ins_valid_d = 1'b1;
                state_d     = S_ISSUE;
                // pc parks on the last address; the overflow is reported when that beat retires.
                if (pc_q == PC_MAX) begin
                    wrap_pending_d = 1'b1;
                end else begin
                    pc_d = pc_inc;
                end
            end
        end

        if (abort) begin
            state_d        = S_IDLE;
            ins_valid_d    = 1'b0;
            loop_active_d  = 1'b0;
            loop_cnt_d     = '0;
            wrap_pending_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= S_IDLE;
            pc_q           <= '0;
            loop_active_q  <= 1'b0;
            loop_cnt_q     <= '0;
            wrap_pending_q <= 1'b0;
            ins_valid_q    <= 1'b0;
            ins_data_q     <= '0;
            error_q        <= 1'b0;
        end else begin
            state_q        <= state_d;
            pc_q           <= pc_d;
            loop_active_q  <= loop_active_d;
            loop_cnt_q     <= loop_cnt_d;
            wrap_pending_q <= wrap_pending_d;
            ins_valid_q    <= ins_valid_d;
            ins_data_q     <= ins_data_d;
            error_q        <= error_d;
        end
    end

    assign icache_rd_ctrl_en   = fetch_go;
    assign icache_rd_ctrl_addr = pc_q;
    assign ins_valid           = ins_valid_q;
    assign ins_data            = ins_data_q;
    assign busy                = (state_q != S_IDLE);
    assign done                = (state_q == S_DONE);
    assign error               = error_q;
    assign pc                  = pc_q;

`ifdef IFU_PERF_CNT_EN
    localparam logic [31:0] PERF_MAX = '1;

    logic [31:0] perf_issue_q, perf_issue_d;
    logic [31:0] perf_stall_q, perf_stall_d;

    always_comb begin
        perf_issue_d = perf_issue_q;
        perf_stall_d = perf_stall_q;
        if (start_go) begin
            perf_issue_d = '0;
            perf_stall_d = '0;
        end else begin
            if (ins_valid_q && ins_ready && (perf_issue_q != PERF_MAX)) begin
                perf_issue_d = perf_issue_q + 32'd1;
            end
            if (ins_valid_q && !ins_ready && (perf_stall_q != PERF_MAX)) begin
                perf_stall_d = perf_stall_q + 32'd1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_issue_q <= '0;
            perf_stall_q <= '0;
        end else begin
            perf_issue_q <= perf_issue_d;
            perf_stall_q <= perf_stall_d;
        end
    end

    assign perf_issue_cnt = perf_issue_q;
    assign perf_stall_cnt = perf_stall_q;
`endif

endmodule

// File: doc/instruction_fetch_sequencer.md
Name: instruction_fetch_sequencer

Overview:
Sequences program execution out of the 1024-entry instruction store. It drives the store's control read port (enable, 10-bit address, combinational 54-bit data return). It issues instructions to the downstream decoder over a valid/ready handshake. HALT and LOOP are interpreted locally and are never forwarded. The host sees start/abort control plus busy, done and error status.

Parameters:
INS_LEN, 54, instruction width; must match the instruction store data width.
ADDR_W, 10, instruction address width (1024 entries).
CNT_W, 10, loop count field width.

Ports:
clk  input  1  clock
rst  input  1  reset; one clock domain, asynchronous, active-high
start  input  1  one-cycle pulse; accepted only in IDLE
start_pc  input  ADDR_W  first fetch address, sampled with start
abort  input  1  synchronous return to IDLE from any state
icache_rd_ctrl_en  output  1  store read enable
icache_rd_ctrl_addr  output  ADDR_W  store read address; always equals the pc register
icache_rd_ctrl_data  input  INS_LEN  store read data, valid in the same cycle as en
ins_valid  output  1  instruction available downstream
ins_data  output  INS_LEN  registered instruction
ins_ready  input  1  downstream accepts
busy  output  1  state != IDLE
done  output  1  one-cycle pulse on program end
error  output  1  sticky program-counter overflow flag; cleared by the next accepted start
pc  output  ADDR_W  current fetch address

Behaviour:
- Opcode field = data[INS_LEN-1 -: 4]. HALT = 4'hF. LOOP = 4'hE, with count = data[ADDR_W+CNT_W-1:ADDR_W] and target = data[ADDR_W-1:0]. Any other opcode is a normal instruction.
- Reset values: all outputs 0, pc 0, loop_active 0, loop_cnt 0, state IDLE.
- States: IDLE, FETCH, ISSUE, DONE.
- IDLE:
  - start: pc<=start_pc, error<=0, loop cleared, go to FETCH.
  - start while not in IDLE is ignored.
- Fetch action (in FETCH, or in ISSUE in the cycle where ins_ready=1):
  - icache_rd_ctrl_en=1; data is decoded in the same cycle.
  - Normal instruction: ins_data<=data, ins_valid<=1, pc<=pc+1, state ISSUE.
    - If pc==2^ADDR_W-1, set wrap_pending instead of wrapping pc.
  - HALT: ins_valid<=0, go to DONE.
  - LOOP (not issued, ins_valid<=0, state FETCH):
    - Not active, count==0: pc<=pc+1.
    - Not active, count>0: loop_cnt<=count, loop_active<=1, pc<=target.
    - Active, loop_cnt>1: loop_cnt<=loop_cnt-1, pc<=target.
    - Active, loop_cnt==1: loop_active<=0, pc<=pc+1.
    - Net effect: body executes count+1 times. Single nesting level; inner LOOP while active reuses the same counter.
- ISSUE:
  - ins_valid and ins_data held stable while ins_ready=0.
  - Handshake with wrap_pending: error<=1, ins_valid<=0, no fetch, go to DONE.
  - Handshake without wrap_pending: perform the fetch action in the same cycle. Back-to-back throughput is 1 instruction/cycle.
- DONE: done=1 for exactly one cycle, then IDLE.
- icache_rd_ctrl_en is 0 in IDLE, DONE, and in ISSUE while ins_ready=0.
- abort (highest priority over start, ready and fetch): next state IDLE, ins_valid<=0, loop cleared, no done pulse, error unchanged.
- Async rst mid-program: immediate return to reset values; any in-flight instruction is lost.
- Latency: start -> first ins_valid = 2 cycles (start registered, fetch in FETCH, valid the next cycle).

Optional Feature:
Macro IFU_PERF_CNT_EN.
- Defined: adds output ports perf_issue_cnt[31:0] and perf_stall_cnt[31:0].
  - perf_issue_cnt increments on each ins_valid&&ins_ready.
  - perf_stall_cnt increments on each ins_valid&&!ins_ready.
  - Both clear on accepted start and on rst; both saturate at 2^32-1.
- Undefined: the ports and counters do not exist; all other behaviour is identical.

Test Plan:
1. Store[5..7]=normal opcodes 1,2,3, store[8]=HALT; start with start_pc=5, ins_ready=1 -> ins_valid high 3 consecutive cycles carrying store[5],[6],[7]; done pulses 1 cycle later; busy falls with done; error=0.
2. Same program, ins_ready=0 for 4 cycles on the first beat -> ins_data=store[5] held 4 cycles; icache_rd_ctrl_en=0 during the stall; then the remaining beats are back-to-back.
3. Store[0]=A, store[1]=LOOP count=2 target=0, store[2]=HALT; start_pc=0 -> issued sequence A,A,A, then done; LOOP never appears on ins_data.
4. start_pc=1023 with store[1023] normal -> one beat issued, then done with error=1 and no fetch from address 0; a new start clears error.
5. abort asserted during ISSUE with ins_valid=1 -> next cycle ins_valid=0, busy=0, no done pulse; a following start at start_pc=5 runs scenario 1 correctly.
6. rst asserted mid-stream -> all outputs 0 immediately without a clock edge. With IFU_PERF_CNT_EN, scenario 2 ends with perf_issue_cnt=3 and perf_stall_cnt=4.
